// File: rtl/regbank_write_arbiter.sv
// Register bank write-port arbiter: three one-entry holding registers drained
// round-robin into a registered bank write, with WAW blocking and a
// pending-write bitmap for hazard detection.
module regbank_write_arbiter #(
  parameter int unsigned REGISTER_SIZE = 32,
  parameter int unsigned ADDRESS_SIZE  = 5,
  parameter bit          ZERO_DISCARD  = 1'b1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            src0_valid,
  input  logic [ADDRESS_SIZE-1:0]         src0_addr,
  input  logic [REGISTER_SIZE-1:0]        src0_data,
  output logic                            src0_ready,
  input  logic                            src1_valid,
  input  logic [ADDRESS_SIZE-1:0]         src1_addr,
  input  logic [REGISTER_SIZE-1:0]        src1_data,
  output logic                            src1_ready,
  input  logic                            src2_valid,
  input  logic [ADDRESS_SIZE-1:0]         src2_addr,
  input  logic [REGISTER_SIZE-1:0]        src2_data,
  output logic                            src2_ready,
  output logic                            rf_write,
  output logic [ADDRESS_SIZE-1:0]         rf_addr,
  output logic [REGISTER_SIZE-1:0]        rf_data,
  output logic [(1<<ADDRESS_SIZE)-1:0]    pending
);

  localparam int unsigned NUM_SRC  = 3;
  localparam int unsigned NUM_REGS = 1 << ADDRESS_SIZE;

  logic [NUM_SRC-1:0]                     in_valid;
  logic [NUM_SRC-1:0][ADDRESS_SIZE-1:0]   in_addr;
  logic [NUM_SRC-1:0][REGISTER_SIZE-1:0]  in_data;

  logic [NUM_SRC-1:0]                     full_q, full_n;
  logic [NUM_SRC-1:0][ADDRESS_SIZE-1:0]   addr_q, addr_n;
  logic [NUM_SRC-1:0][REGISTER_SIZE-1:0]  data_q, data_n;
  logic [1:0]                             last_q, last_n;

  logic                                   rf_write_n;
  logic [ADDRESS_SIZE-1:0]                rf_addr_n;
  logic [REGISTER_SIZE-1:0]               rf_data_n;
  logic [NUM_REGS-1:0]                    pending_n;

  logic [NUM_SRC-1:0]                     grant;
  logic [1:0]                             grant_idx;
  logic                                   grant_any;
  logic [NUM_SRC-1:0]                     is_zero;
  logic [NUM_SRC-1:0]                     waw_block;
  logic [NUM_SRC-1:0]                     ready;
  logic [NUM_SRC-1:0]                     accept;

  // Gather the per-source ports into indexable vectors
  always_comb begin
    in_valid = {src2_valid, src1_valid, src0_valid};
    in_addr  = {src2_addr, src1_addr, src0_addr};
    in_data  = {src2_data, src1_data, src0_data};
  end

  // Round-robin grant over registered full bits, starting after last grant
  always_comb begin
    logic [1:0] idx;
    grant     = '0;
    grant_idx = 2'd0;
    grant_any = 1'b0;
    idx       = 2'd0;
    for (int unsigned off = 1; off <= NUM_SRC; off++) begin
      idx = 2'((32'(last_q) + off) % NUM_SRC);
      if (!grant_any && full_q[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        grant_any  = 1'b1;
      end
    end
  end

  // WAW blocking and ready; lower-index sources win same-cycle address ties
  always_comb begin
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      is_zero[k]   = ZERO_DISCARD && (in_addr[k] == '0);
      waw_block[k] = 1'b0;
      for (int j = 0; j < int'(NUM_SRC); j++) begin
        if (!is_zero[k] && (j != k) && full_q[j] && !grant[j] &&
            (addr_q[j] == in_addr[k]))
          waw_block[k] = 1'b1;
        if (!is_zero[k] && (j < k) && in_valid[j] && (in_addr[j] == in_addr[k]))
          waw_block[k] = 1'b1;
      end
      ready[k]  = !reset && (!full_q[k] || grant[k]) && !waw_block[k];
      accept[k] = in_valid[k] && ready[k];
    end
  end

  assign src0_ready = ready[0];
  assign src1_ready = ready[1];
  assign src2_ready = ready[2];

  // Next state: issue the granted entry, then load accepted writes
  always_comb begin
    full_n     = full_q;
    addr_n     = addr_q;
    data_n     = data_q;
    last_n     = last_q;
    rf_write_n = 1'b0;
    rf_addr_n  = rf_addr;
    rf_data_n  = rf_data;
    pending_n  = pending;
    if (grant_any) begin
      rf_write_n                   = 1'b1;
      rf_addr_n                    = addr_q[grant_idx];
      rf_data_n                    = data_q[grant_idx];
      last_n                       = grant_idx;
      full_n[grant_idx]            = 1'b0;
      pending_n[addr_q[grant_idx]] = 1'b0;
    end
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      if (accept[k] && !is_zero[k]) begin
        full_n[k]             = 1'b1;
        addr_n[k]             = in_addr[k];
        data_n[k]             = in_data[k];
        pending_n[in_addr[k]] = 1'b1;
      end
    end
  end

  // State registers; reset drops held entries without writing
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q   <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      last_q   <= 2'd2;
      rf_write <= 1'b0;
      rf_addr  <= '0;
      rf_data  <= '0;
      pending  <= '0;
    end else begin
      full_q   <= full_n;
      addr_q   <= addr_n;
      data_q   <= data_n;
      last_q   <= last_n;
      rf_write <= rf_write_n;
      rf_addr  <= rf_addr_n;
      rf_data  <= rf_data_n;
      pending  <= pending_n;
    end
  end

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Randomized bench for regbank_write_arbiter against a behavioural model of
// the holding entries, round-robin order and WAW rules.
module tb_regbank_write_arbiter;

  localparam int unsigned RS = 32;
  localparam int unsigned AS = 5;
  localparam int unsigned NR = 1 << AS;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    sv;
  logic [AS-1:0] sa [3];
  logic [RS-1:0] sd [3];
  logic          r0, r1, r2;
  logic          rf_write;
  logic [AS-1:0] rf_addr;
  logic [RS-1:0] rf_data;
  logic [NR-1:0] pending;

  int vectors = 0;
  int miscompares = 0;

  // Model state
  bit            m_full [3];
  logic [AS-1:0] m_addr [3];
  logic [RS-1:0] m_data [3];
  int            m_last;
  bit            m_wr;
  logic [AS-1:0] m_raddr;
  logic [RS-1:0] m_rdata;

  always #5 clk = ~clk;

  regbank_write_arbiter #(.REGISTER_SIZE(RS), .ADDRESS_SIZE(AS), .ZERO_DISCARD(1'b1)) dut (
    .clk(clk), .reset(reset),
    .src0_valid(sv[0]), .src0_addr(sa[0]), .src0_data(sd[0]), .src0_ready(r0),
    .src1_valid(sv[1]), .src1_addr(sa[1]), .src1_data(sd[1]), .src1_ready(r1),
    .src2_valid(sv[2]), .src2_addr(sa[2]), .src2_data(sd[2]), .src2_ready(r2),
    .rf_write(rf_write), .rf_addr(rf_addr), .rf_data(rf_data), .pending(pending)
  );

  function automatic int m_grant();
    for (int off = 1; off <= 3; off++) begin
      int i = (m_last + off) % 3;
      if (m_full[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit m_ready(int k);
    int g = m_grant();
    if (reset) return 1'b0;
    if (m_full[k] && g != k) return 1'b0;
    if (sa[k] == '0) return 1'b1;
    for (int j = 0; j < 3; j++) begin
      if (j != k && m_full[j] && j != g && m_addr[j] == sa[k]) return 1'b0;
      if (j < k && sv[j] && sa[j] == sa[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [NR-1:0] m_pending();
    logic [NR-1:0] p = '0;
    for (int k = 0; k < 3; k++)
      if (m_full[k]) p[m_addr[k]] = 1'b1;
    return p;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_full[k] = 1'b0; m_addr[k] = '0; m_data[k] = '0;
    end
    m_last = 2; m_wr = 1'b0; m_raddr = '0; m_rdata = '0;
  endtask

  // One clock: check ready mid-cycle, advance model, check registered outputs
  task automatic cycle();
    bit rdy [3];
    int g;
    @(negedge clk);
    for (int k = 0; k < 3; k++) rdy[k] = m_ready(k);
    check("src0_ready", 64'(r0), 64'(rdy[0]));
    check("src1_ready", 64'(r1), 64'(rdy[1]));
    check("src2_ready", 64'(r2), 64'(rdy[2]));
    g = m_grant();
    if (reset) begin
      model_reset();
    end else begin
      if (g >= 0) begin
        m_wr = 1'b1; m_raddr = m_addr[g]; m_rdata = m_data[g];
        m_last = g; m_full[g] = 1'b0;
      end else begin
        m_wr = 1'b0;
      end
      for (int k = 0; k < 3; k++)
        if (sv[k] && rdy[k] && sa[k] != '0) begin
          m_full[k] = 1'b1; m_addr[k] = sa[k]; m_data[k] = sd[k];
        end
    end
    @(posedge clk);
    #1;
    check("rf_write", 64'(rf_write), 64'(m_wr));
    check("rf_addr", 64'(rf_addr), 64'(m_raddr));
    check("rf_data", 64'(rf_data), 64'(m_rdata));
    check("pending", 64'(pending), 64'(m_pending()));
  endtask

  task automatic set_src(input int k, input logic v, input logic [AS-1:0] a, input logic [RS-1:0] d);
    sv[k] = v; sa[k] = a; sd[k] = d;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) set_src(k, 1'b0, '0, '0);
  endtask

  initial begin
    logic [AS-1:0] seen [6];
    logic [AS-1:0] exp_rr [6];
    exp_rr = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
    model_reset();
    idle_all();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;

    // Single write with 2-cycle latency
    set_src(0, 1'b1, 5'd5, 32'hDEADBEEF);
    cycle();
    check("single_pend5", 64'(pending[5]), 64'd1);
    idle_all();
    cycle();
    check("single_wr", 64'(rf_write), 64'd1);
    check("single_addr", 64'(rf_addr), 64'd5);
    check("single_data", 64'(rf_data), 64'hDEADBEEF);
    cycle();
    check("single_one_cycle", 64'(rf_write), 64'd0);
    check("single_pend_clr", 64'(pending), 64'd0);

    // Round-robin from a fresh pointer
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 3; k++) set_src(k, 1'b1, AS'(k + 1), $urandom);
      cycle();
      if (i >= 1 && i <= 6) seen[i-1] = rf_addr;
    end
    for (int i = 0; i < 6; i++) check("rr_order", 64'(seen[i]), 64'(exp_rr[i]));
    idle_all();
    repeat (4) cycle();

    // WAW on address 7
    set_src(0, 1'b1, 5'd7, 32'hAAAA0000);
    set_src(1, 1'b1, 5'd7, 32'hBBBB1111);
    cycle();
    check("waw_pend7_a", 64'(pending[7]), 64'd1);
    set_src(0, 1'b0, '0, '0);
    #1;
    check("waw_src1_ready", 64'(r1), 64'd1);
    cycle();
    check("waw_first_data", 64'(rf_data), 64'hAAAA0000);
    check("waw_pend7_b", 64'(pending[7]), 64'd1);
    idle_all();
    cycle();
    check("waw_second_data", 64'(rf_data), 64'hBBBB1111);
    check("waw_pend7_clr", 64'(pending[7]), 64'd0);
    cycle();

    // Zero discard
    set_src(2, 1'b1, 5'd0, 32'h12345678);
    #1;
    check("zero_ready", 64'(r2), 64'd1);
    cycle();
    idle_all();
    cycle();
    check("zero_no_write", 64'(rf_write), 64'd0);
    check("zero_pending", 64'(pending), 64'd0);

    // Reset mid-operation
    for (int k = 0; k < 3; k++) set_src(k, 1'b1, AS'(k + 4), $urandom);
    cycle();
    idle_all();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("rst_no_write", 64'(rf_write), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    set_src(0, 1'b1, 5'd9, 32'h0BADF00D);
    #1;
    check("rst_ready_after", 64'(r0), 64'd1);
    cycle();
    idle_all();
    repeat (3) cycle();

    // Back-to-back single source
    for (int i = 0; i < 10; i++) begin
      if (i < 8) set_src(1, 1'b1, AS'(10 + i), $urandom);
      else set_src(1, 1'b0, '0, '0);
      cycle();
      if (i >= 1 && i <= 8) begin
        check("b2b_write", 64'(rf_write), 64'd1);
        check("b2b_addr", 64'(rf_addr), 64'(10 + i - 1));
      end
    end

    // Randomized traffic with narrow address range to provoke WAW
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 3; k++)
        set_src(k, 1'($urandom_range(0, 1)), AS'($urandom_range(0, 7)), $urandom);
      reset = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 1'b0;
    idle_all();
    repeat (4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regbank_write_arbiter.md
# regbank_write_arbiter

Shares the single write port of the register bank among three writeback sources: ALU, memory load and multiply/auxiliary unit. Each source has a valid/ready handshake into a one-entry holding register. A round-robin arbiter drains one holding register per cycle into registered bank write signals. A pending-write bitmap is exported for hazard detection. The block sits between the execute/memory stages and the register bank write inputs.

## Interface
- REGISTER_SIZE, 32, data width; must match the register bank.
- ADDRESS_SIZE, 5, register address width; the bank has 2^ADDRESS_SIZE entries.
- ZERO_DISCARD, 1, when 1, writes to address 0 are accepted and dropped.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- srcK_valid  in  1  (K = 0, 1, 2: 0 = ALU, 1 = memory, 2 = auxiliary) source K has a write.
- srcK_addr  in  ADDRESS_SIZE  destination register.
- srcK_data  in  REGISTER_SIZE  write data.
- srcK_ready  out  1  source K transfer accepted this cycle when valid and ready are both high.
- rf_write  out  1  to the bank write input; registered.
- rf_addr  out  ADDRESS_SIZE  to the bank addr_in; registered.
- rf_data  out  REGISTER_SIZE  to the bank data_in; registered.
- pending  out  2^ADDRESS_SIZE  bit i set while a write to register i is held and not yet issued.

## Operation
- Holding entry K stores {full, addr, data}.
- Grant: one full entry per cycle, chosen by round-robin.
  - Search starts at the index after the last granted one.
  - The last-grant pointer updates only on a grant.
  - Grant depends only on registered full bits.
- Issue edge: at the edge ending a grant cycle:
  - rf_write <= 1, rf_addr and rf_data <= the granted entry.
  - Entry K clears unless it is refilled on the same edge.
  - With no grant, rf_write <= 0 and rf_addr/rf_data hold their values.
- srcK_ready = !reset && (!fullK || grantK) && !waw_blockK.
  - This allows same-edge drain and refill, giving one transfer per cycle per source.
- WAW blocking ensures at most one outstanding write per address and in-order writes per address.
  - waw_blockK is high when srcK_addr matches a full entry J≠K that is not granted this cycle.
  - waw_blockK is also high when srcK_addr matches srcJ_addr for a valid J<K in the same cycle; the lower index wins.
  - Within one source, a new write to the same address as its own draining entry is allowed.
- Zero discard: with ZERO_DISCARD=1 and addr 0, the transfer is accepted and the entry is not loaded. Pending is not set. WAW checks ignore address 0.
- pending[i] is set on the accept edge for address i.
  - It is cleared on the issue edge of address i, unless re-accepted on that edge, in which case it stays set.
  - Invariant: pending is the OR of the one-hot full-entry addresses.

## Timing
- Reset values: all full bits 0, last-grant pointer = 2 (src0 searched first), rf_write 0, rf_addr 0, rf_data 0, pending all 0.
  - srcK_ready is 0 while reset is high.
- Reset mid-operation discards all held entries without writing; rf_write is 0 the cycle after the reset edge.
- Latency: accept at edge E0 → earliest grant in the cycle after E0 → rf_write high in the cycle after issue edge E1. That is 2 cycles from handshake to the write cycle.
- rf_write/rf_addr/rf_data are stable for a full cycle, covering the bank's low-phase write.
- Throughput: one bank write per cycle total. With all three sources full, each is served every 3rd cycle.
- No starvation: a full entry is granted within 3 cycles.
- srcK_ready may combinationally depend on any srcJ_valid/srcJ_addr (J<K) and registered state. There is no path from srcK_valid to srcK_ready.

## Test plan
- Single write: after reset, src0 writes addr 5, data 0xDEADBEEF for one cycle. Required: rf_write=1, rf_addr=5, rf_data=0xDEADBEEF exactly 2 cycles later for one cycle. pending[5] is high between accept and issue.
- Round-robin: all three sources valid continuously to addrs 1, 2, 3. Required: issue order 1, 2, 3, 1, 2, 3…, rf_write high every cycle once primed, and each ready high every third cycle.
- WAW: src0 and src1 both valid for addr 7 in the same cycle. Required: src0 accepted and src1 ready low. src1 is accepted on the issue edge of src0's write. Bank sees src0 data then src1 data, and pending[7] stays high throughout.
- Zero discard: src2 writes addr 0. Required: ready high, no rf_write, pending unchanged.
- Reset mid-operation: fill all three entries, assert reset one cycle. Required: no further rf_write, pending=0, ready low during reset and high the cycle after.
- Back-to-back single source: src1 valid for 8 cycles, addrs 10..17. Required: ready high every cycle and 8 consecutive rf_write cycles in order.
